// File: rtl/score_ram_arbiter.sv
// Round-robin arbiter sharing the single-port 32x16 score RAM between three requesters,
// with lock-based ownership retention for read-modify-write sequences.
//   state | meaning
//   IDLE  | no owner, arbitrate among pending requests
//   ISSUE | drive RAM address/data/RW from the latched op
//   WAIT  | hold RAM pins for RAM_LAT cycles, then ack (and capture read data)
//   DONE  | ack cleared, requests ignored, decide hold or release
//   HOLD  | locked owner keeps gnt, waits for its next op or lock drop/timeout
module score_ram_arbiter #(
  parameter int RAM_LAT = 3,
  parameter int LOCK_TO = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [2:0]  rw,
  input  logic [14:0] addr,
  input  logic [47:0] din,
  output logic [2:0]  gnt,
  output logic [2:0]  ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        err_timeout,
  output logic [4:0]  scoreRAM_Addr,
  output logic [15:0] scoreRAM_Din,
  output logic        scoreRAM_RW,
  input  logic [15:0] scoreRAM_Dout
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HOLD} stateT;

  localparam logic [3:0] CNT_LAST = 4'(RAM_LAT - 1);
  localparam logic [7:0] TO_LAST  = 8'(LOCK_TO - 1);

  stateT       state;
  logic [1:0]  last;
  logic        opRw;
  logic [4:0]  opAddr;
  logic [15:0] opDin;
  logic [3:0]  cnt;
  logic [7:0]  toCnt;

  logic [1:0]  firstIdx, secondIdx, winner, selIdx;
  logic [2:0]  winGnt;
  logic        selRw;
  logic [4:0]  selAddr;
  logic [15:0] selDin;
  logic        ownReq, ownLock;

  function automatic logic [1:0] nextIdx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic bitOf(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  always_comb begin
    firstIdx  = nextIdx(last);
    secondIdx = nextIdx(firstIdx);
    winner    = bitOf(req, firstIdx)  ? firstIdx  :
                bitOf(req, secondIdx) ? secondIdx : last;
    winGnt    = 3'b001 << winner;
    // in HOLD the owner is always the last winner, so no re-arbitration
    selIdx    = (state == HOLD) ? last : winner;
    case (selIdx)
      2'd0: begin
        selRw = rw[0]; selAddr = addr[4:0];   selDin = din[15:0];
      end
      2'd1: begin
        selRw = rw[1]; selAddr = addr[9:5];   selDin = din[31:16];
      end
      default: begin
        selRw = rw[2]; selAddr = addr[14:10]; selDin = din[47:32];
      end
    endcase
    ownReq  = |(req & gnt);
    ownLock = |(lock & gnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last          <= 2'd2;
      gnt           <= 3'b000;
      ack           <= 3'b000;
      rdata         <= 16'h0000;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      scoreRAM_Addr <= 5'd0;
      scoreRAM_Din  <= 16'h0000;
      scoreRAM_RW   <= 1'b0;
      opRw          <= 1'b0;
      opAddr        <= 5'd0;
      opDin         <= 16'h0000;
      cnt           <= 4'd0;
      toCnt         <= 8'd0;
    end else begin
      ack         <= 3'b000;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          opRw   <= selRw;
          opAddr <= selAddr;
          opDin  <= selDin;
          gnt    <= winGnt;
          last   <= winner;
          busy   <= 1'b1;
          state  <= ISSUE;
        end
        ISSUE: begin
          scoreRAM_Addr <= opAddr;
          scoreRAM_Din  <= opDin;
          scoreRAM_RW   <= opRw;
          cnt           <= 4'd0;
          state         <= WAIT;
        end
        WAIT: if (cnt == CNT_LAST) begin
          if (!opRw) rdata <= scoreRAM_Dout;
          ack         <= gnt;
          scoreRAM_RW <= 1'b0;
          state       <= DONE;
        end else begin
          cnt <= cnt + 4'd1;
        end
        DONE: if (ownLock) begin
          toCnt <= 8'd0;
          state <= HOLD;
        end else begin
          gnt   <= 3'b000;
          busy  <= 1'b0;
          state <= IDLE;
        end
        HOLD: if (ownReq) begin
          opRw   <= selRw;
          opAddr <= selAddr;
          opDin  <= selDin;
          state  <= ISSUE;
        end else if (!ownLock) begin
          gnt   <= 3'b000;
          busy  <= 1'b0;
          state <= IDLE;
        end else if (toCnt == TO_LAST) begin
          gnt         <= 3'b000;
          busy        <= 1'b0;
          err_timeout <= 1'b1;
          state       <= IDLE;
        end else begin
          toCnt <= toCnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_ram_arbiter.sv
// Bench for score_ram_arbiter: directed scenarios with literal expectations plus a
// transaction-timeline reference model compared against every output each cycle.
module tb_score_ram_arbiter;
  localparam int RAM_LAT = 3;
  localparam int LOCK_TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0, lock = '0, rw = '0;
  logic [14:0] addr = '0;
  logic [47:0] din = '0;
  logic [2:0]  gnt, ack;
  logic [15:0] rdata;
  logic        busy, err_timeout;
  logic [4:0]  scoreRAM_Addr;
  logic [15:0] scoreRAM_Din;
  logic        scoreRAM_RW;
  logic [15:0] scoreRAM_Dout;

  logic [15:0] ram [32];
  logic [15:0] modelMem [32];
  logic [15:0] initImage [32];
  logic        preload = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_ram_arbiter #(.RAM_LAT(RAM_LAT), .LOCK_TO(LOCK_TO)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .rw(rw), .addr(addr), .din(din),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .err_timeout(err_timeout),
    .scoreRAM_Addr(scoreRAM_Addr), .scoreRAM_Din(scoreRAM_Din),
    .scoreRAM_RW(scoreRAM_RW), .scoreRAM_Dout(scoreRAM_Dout)
  );

  // RAM behind the arbiter: asynchronous read, write on the edge while RW is high
  assign scoreRAM_Dout = ram[scoreRAM_Addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 32; k++) ram[k] <= initImage[k];
    end else if (scoreRAM_RW) begin
      ram[scoreRAM_Addr] <= scoreRAM_Din;
    end
  end

  // Reference model: ownership and per-transaction age in edges since the op was taken
  int          mOwner, mAge, mIdle, mLast, mAddr;
  bit          mHolding, mRw, found;
  logic [15:0] mDin;
  logic [2:0]  eAck;
  logic [15:0] eRdata, eDinPin;
  logic [4:0]  eAddrPin;
  bit          eRw, eErr;

  task automatic takeOp(input int i);
    mOwner   = i;
    mAge     = 0;
    mHolding = 0;
    mRw      = rw[i];
    mAddr    = int'(addr[5*i +: 5]);
    mDin     = din[16*i +: 16];
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (preload) for (int k = 0; k < 32; k++) modelMem[k] = initImage[k];
      mOwner = -1; mLast = 2; mHolding = 0; mAge = 0; mIdle = 0;
      eAck = 0; eRdata = 0; eAddrPin = 0; eDinPin = 0; eRw = 0; eErr = 0;
    end else begin
      eAck = 0;
      eErr = 0;
      if (mOwner < 0) begin
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          if (!found && req[(mLast + k) % 3]) begin
            found = 1;
            mLast = (mLast + k) % 3;
            takeOp(mLast);
          end
        end
      end else if (mHolding) begin
        if (req[mOwner]) takeOp(mOwner);
        else if (!lock[mOwner]) mOwner = -1;
        else begin
          mIdle++;
          if (mIdle == LOCK_TO) begin mOwner = -1; eErr = 1; end
        end
      end else begin
        mAge++;
        if (mAge == 1) begin eAddrPin = 5'(mAddr); eDinPin = mDin; eRw = mRw; end
        if (mAge == 2 && mRw) modelMem[mAddr] = mDin;
        if (mAge == RAM_LAT + 1) begin
          eAck = 3'b001 << mOwner;
          eRw  = 0;
          if (!mRw) eRdata = modelMem[mAddr];
        end
        if (mAge == RAM_LAT + 2) begin
          if (lock[mOwner]) begin mHolding = 1; mIdle = 0; end
          else mOwner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0]  eGnt;
    logic [47:0] act, exp;
    eGnt = (mOwner < 0) ? 3'b000 : (3'b001 << mOwner);
    act  = {gnt, ack, rdata, busy, err_timeout, scoreRAM_Addr, scoreRAM_Din, scoreRAM_RW};
    exp  = {eGnt, eAck, eRdata, (mOwner >= 0), eErr, eAddrPin, eDinPin, eRw};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_cycle t=%0t got gnt=%b ack=%b rdata=%h busy=%b err=%b A=%h D=%h RW=%b want gnt=%b ack=%b rdata=%h busy=%b err=%b A=%h D=%h RW=%b",
               $time, gnt, ack, rdata, busy, err_timeout, scoreRAM_Addr, scoreRAM_Din, scoreRAM_RW,
               eGnt, eAck, eRdata, mOwner >= 0, eErr, eAddrPin, eDinPin, eRw);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setOp(input int i, input logic r, input logic [4:0] a, input logic [15:0] d);
    rw[i]           = r;
    addr[5*i +: 5]  = a;
    din[16*i +: 16] = d;
  endtask

  task automatic waitAck(input int i, input string nm);
    bit got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      tick();
      if (ack[i]) got = 1;
    end
    chk(nm, got, 1);
  endtask

  int  rwHigh;
  bit  got;

  initial begin
    for (int k = 0; k < 32; k++) initImage[k] = 16'($urandom);
    initImage[1] = 16'h0042;
    initImage[7] = 16'h0777;
    #3;
    chk("reset_gnt_ack", {gnt, ack}, 0);
    chk("reset_busy_err", {busy, err_timeout}, 0);
    chk("reset_pins", {scoreRAM_Addr, scoreRAM_Din, scoreRAM_RW, rdata}, 0);
    tick(); tick();
    preload = 0;
    rst = 1;
    tick();

    // single read
    setOp(0, 0, 5'd1, 16'h0); req[0] = 1;
    tick(); chk("read_gnt", gnt, 3'b001);
    for (int k = 0; k < 3; k++) begin
      tick(); chk("read_addr", {scoreRAM_Addr, scoreRAM_RW}, {5'd1, 1'b0});
    end
    tick(); chk("read_ack", ack, 3'b001); chk("read_rdata", rdata, 16'h0042);
    req[0] = 0;
    tick(); chk("read_release", {gnt, ack}, 0);

    // write then read back
    setOp(1, 1, 5'd5, 16'h1234); req[1] = 1;
    tick(); chk("write_gnt", gnt, 3'b010);
    rwHigh = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (scoreRAM_RW) begin
        rwHigh++;
        chk("write_pins", {scoreRAM_Addr, scoreRAM_Din}, {5'd5, 16'h1234});
      end
    end
    chk("write_ack", ack, 3'b010);
    chk("write_rw_cycles", rwHigh, RAM_LAT);
    req[1] = 0;
    tick();
    setOp(2, 0, 5'd5, 16'h0); req[2] = 1;
    waitAck(2, "readback_ack");
    chk("readback_rdata", rdata, 16'h1234);
    req[2] = 0;
    tick();

    // round robin with all three requesting continuously
    setOp(0, 0, 5'd0, 0); setOp(1, 0, 5'd1, 0); setOp(2, 0, 5'd2, 0);
    req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        tick();
        if (|ack) got = 1;
      end
      chk("rr_ack_seen", got, 1);
      chk("rr_order", ack, 3'b001 << (n % 3));
      if (n == 5) req = 3'b000;
    end
    tick();

    // locked read-modify-write by requester 0 while requester 1 waits
    setOp(0, 0, 5'd1, 0); lock[0] = 1;
    setOp(1, 0, 5'd7, 0);
    req = 3'b011;
    waitAck(0, "rmw_read_ack");
    chk("rmw_read_rdata", rdata, 16'h0042);
    setOp(0, 1, 5'd1, 16'hABCD);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      chk("rmw_gnt_held", gnt, 3'b001);
      if (ack[0]) got = 1;
    end
    chk("rmw_write_ack", got, 1);
    req[0] = 0;
    tick(); chk("rmw_hold1", gnt, 3'b001);
    tick(); chk("rmw_hold2", gnt, 3'b001);
    lock[0] = 0;
    tick(); chk("rmw_release", gnt, 3'b000);
    tick(); chk("rmw_next_gnt", gnt, 3'b010);
    waitAck(1, "rmw_r1_ack");
    chk("rmw_r1_rdata", rdata, 16'h0777);
    req[1] = 0;
    tick();

    // lock timeout on requester 2 with requester 0 pending
    setOp(2, 0, 5'd3, 0); lock[2] = 1; req[2] = 1;
    waitAck(2, "to_ack");
    req[2] = 0;
    setOp(0, 0, 5'd1, 0); req[0] = 1;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("to_hold_gnt", {gnt, err_timeout}, {3'b100, 1'b0});
    end
    tick(); chk("to_fire", {gnt, err_timeout}, {3'b000, 1'b1});
    tick(); chk("to_after", {gnt, err_timeout}, {3'b001, 1'b0});
    lock[2] = 0;
    waitAck(0, "to_r0_ack");
    req[0] = 0;
    tick();

    // reset during the WAIT phase of a write
    setOp(1, 1, 5'd9, 16'h5555); req[1] = 1;
    tick(); chk("rst_w_gnt", gnt, 3'b010);
    tick(); chk("rst_w_rw", scoreRAM_RW, 1);
    tick();
    rst = 0;
    #1;
    chk("rst_w_abort", {scoreRAM_RW, gnt, busy}, 0);
    req = 0; lock = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); chk("rst_w_noack", ack, 0);
    end
    rst = 1;
    setOp(0, 0, 5'd9, 0); setOp(1, 0, 5'd7, 0); setOp(2, 0, 5'd1, 0);
    req = 3'b111;
    tick(); chk("rst_first_gnt", gnt, 3'b001);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 0;
          if ($urandom_range(0, 2) == 0) lock[i] = 0;
        end else if (!req[i]) begin
          if (lock[i] && $urandom_range(0, 5) == 0) lock[i] = 0;
          if ($urandom_range(0, 3) == 0) begin
            setOp(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom));
            lock[i] = ($urandom_range(0, 3) == 0);
            req[i]  = 1;
          end
        end
      end
    end
    req = 0; lock = 0;
    repeat (20) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
